apb_arbiter: RTL and testbench
==============================

APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter: ADDR_W, 8, APB address width.
REQ-002 Parameter: DATA_W, 32, APB data width.
REQ-003 Parameter: TIMEOUT, 16, maximum ACCESS cycles without PREADY before abort.
REQ-004 PCLK  in  1  the single clock; all state updates on its rising edge.
REQ-005 PRESETn  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  2  per-requester command valid; index 0 and index 1.
REQ-007 req_write  in  2  per-requester direction: 1 = write, 0 = read.
REQ-008 req_addr  in  2*ADDR_W  per-requester address; requester i occupies slice i.
REQ-009 req_wdata  in  2*DATA_W  per-requester write data; requester i occupies slice i.
REQ-010 req_ready  out  2  command accepted this cycle; combinational, at most one bit high.
REQ-011 rsp_valid  out  2  one-cycle completion pulse to the owning requester.
REQ-012 rsp_rdata  out  DATA_W  read data; valid only while rsp_valid is nonzero.
REQ-013 rsp_err  out  1  timeout abort flag; valid only while rsp_valid is nonzero.
REQ-014 PADDR, PWRITE, PWDATA, PSEL, PENABLE  out  ADDR_W/1/DATA_W/1/1  APB master outputs.
REQ-015 PRDATA, PREADY  in  DATA_W/1  APB completer inputs.

Function
REQ-016 FSM states SHALL be IDLE, SETUP and ACCESS.
REQ-017 IDLE: PSEL=0 and PENABLE=0; if any req_valid is high, assert req_ready for the winner, latch its write/addr/wdata, and go to SETUP.
REQ-018 Arbitration SHALL be round-robin: a single requester wins when alone; when both are valid, the requester not granted last wins.
REQ-019 SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA = latched command; the next state SHALL be ACCESS unconditionally.
REQ-020 ACCESS: PSEL=1, PENABLE=1; address, control and data SHALL stay stable until exit.
REQ-021 ACCESS with PREADY=1: next state IDLE; pulse rsp_valid[owner] for one cycle; rsp_rdata = PRDATA for reads and 0 for writes; rsp_err=0.
REQ-022 The wait counter SHALL clear on entering ACCESS and increment on each ACCESS cycle with PREADY=0.
REQ-023 Timeout: when the wait counter reaches TIMEOUT with PREADY=0, go to IDLE; pulse rsp_valid[owner] with rsp_err=1 and rsp_rdata=0.
REQ-024 Zero-wait latency: handshake at edge E0 gives SETUP after E0, ACCESS after E1, and rsp_valid in the cycle after E2.
REQ-025 A new command MAY be accepted in the same IDLE cycle as rsp_valid, so back-to-back transfers have exactly one idle cycle between them.
REQ-026 req_ready SHALL be 0 outside IDLE; req_valid is ignored in SETUP and ACCESS.
REQ-027 PADDR, PWRITE and PWDATA SHALL hold their last values in IDLE; PWRITE=0 after reset.

Reset
REQ-028 PRESETn low SHALL immediately force IDLE, with PSEL, PENABLE, PADDR, PWDATA, PWRITE, rsp_valid, rsp_rdata, rsp_err and the wait counter all 0.
REQ-029 Reset SHALL set the round-robin pointer so requester 0 wins the first contested grant.
REQ-030 Reset during SETUP or ACCESS SHALL abandon the transfer with no rsp_valid pulse.

Structure
REQ-031 Package apb_ctrl_pkg SHALL hold the state enum and the ADDR_W/DATA_W/TIMEOUT defaults.
REQ-032 The grant logic and last-grant pointer SHALL live in one sub-module, apb_rr_arb2.

Verification
REQ-033 Requester 0 writes 8'h01 = 32'h11223344 with PREADY tied 1 -> PSEL for 2 cycles, PENABLE for 1 cycle, rsp_valid=2'b01 exactly 3 cycles after the handshake.
REQ-034 Requester 1 reads 8'h01, slave returns 32'h11223344 with 2 wait states -> rsp_rdata=32'h11223344, rsp_valid=2'b10, rsp_err=0.
REQ-035 Both requesters valid continuously, with req0 writing 8'h02 and req1 writing 8'h03 -> grant order 0,1,0,1 and no requester starved.
REQ-036 PREADY held 0 in ACCESS -> after TIMEOUT=16 wait cycles, rsp_err=1, rsp_rdata=0, return to IDLE.
REQ-037 PRESETn asserted mid-ACCESS -> PSEL and PENABLE drop immediately with no rsp_valid, and the next contested grant goes to requester 0.

Source files
------------

// File: rtl/apb_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// apb_ctrl_pkg
// Shared definitions for the two-requester APB master (apb_arbiter):
//   - default widths and the ACCESS wait-state limit
//   - the transfer FSM state type
// -----------------------------------------------------------------------------
package apb_ctrl_pkg;

    localparam int ADDR_W_DEF  = 8;   // APB address width
    localparam int DATA_W_DEF  = 32;  // APB data width
    localparam int TIMEOUT_DEF = 16;  // ACCESS cycles without PREADY before abort

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage : apb_ctrl_pkg

// File: rtl/apb_rr_arb2.sv
// -----------------------------------------------------------------------------
// apb_rr_arb2
// Two-way round-robin grant logic with its last-grant pointer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : grants may be issued this cycle (controller is idle)
//   req[1:0]   : request vector
//   gnt[1:0]   : one-hot (or zero) grant, combinational from req/en/pointer
// -----------------------------------------------------------------------------
module apb_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Index of the requester granted most recently. Resetting it to 1 makes
    // requester 0 the winner of the first contested grant.
    logic last_q;
    logic last_d;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
            // Any grant, contested or not, moves the pointer.
            if (gnt != 2'b00) begin
                last_d = gnt[1];
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule : apb_rr_arb2

// File: rtl/apb_arbiter.sv
// -----------------------------------------------------------------------------
// apb_arbiter
// Arbitrates two command requesters onto a single APB master port and returns
// a one-cycle completion pulse (with read data or a timeout error) to the
// requester that owned the transfer.
// Ports:
//   PCLK, PRESETn           : clock, asynchronous active-low reset
//   req_valid/req_write[1:0]: per-requester command valid / direction (1=write)
//   req_addr  [2*ADDR_W]    : requester i address in slice i
//   req_wdata [2*DATA_W]    : requester i write data in slice i
//   req_ready[1:0]          : command accepted (combinational, idle only)
//   rsp_valid[1:0]          : completion pulse to the owning requester
//   rsp_rdata, rsp_err      : read data / timeout flag, valid with rsp_valid
//   PADDR..PENABLE          : APB master outputs
//   PRDATA, PREADY          : APB completer inputs
// -----------------------------------------------------------------------------
module apb_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   PADDR,
    output logic                PWRITE,
    output logic [DATA_W-1:0]   PWDATA,
    output logic                PSEL,
    output logic                PENABLE,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    apb_state_e          state_q,     state_d;
    logic                owner_q,     owner_d;
    logic [ADDR_W-1:0]   paddr_q,     paddr_d;
    logic                pwrite_q,    pwrite_d;
    logic [DATA_W-1:0]   pwdata_q,    pwdata_d;
    logic [CNT_W-1:0]    wait_cnt_q,  wait_cnt_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q,   rsp_err_d;

    logic [1:0] gnt;
    logic       win;

    // Grants are only offered while idle; in SETUP/ACCESS req_valid is ignored.
    apb_rr_arb2 u_rr_arb2 (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .en    (state_q == ST_IDLE),
        .req   (req_valid),
        .gnt   (gnt)
    );

    assign win = gnt[1];

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        wait_cnt_d  = '0;
        rsp_valid_d = 2'b00;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    owner_d  = win;
                    pwrite_d = req_write[win];
                    paddr_d  = win ? req_addr[2*ADDR_W-1:ADDR_W]
                                   : req_addr[ADDR_W-1:0];
                    pwdata_d = win ? req_wdata[2*DATA_W-1:DATA_W]
                                   : req_wdata[DATA_W-1:0];
                    state_d  = ST_SETUP;
                end
            end

            ST_SETUP: begin
                state_d = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (PREADY) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // This wait cycle brings the count to TIMEOUT: abort the
                    // transfer, so at most TIMEOUT unready ACCESS cycles occur.
                    state_d     = ST_IDLE;
                    rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                    rsp_err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            wait_cnt_q  <= '0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            wait_cnt_q  <= wait_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = gnt;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign PSEL      = (state_q != ST_IDLE);
    assign PENABLE   = (state_q == ST_ACCESS);

endmodule : apb_arbiter

// File: tb/tb_apb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_arbiter
// Directed stimulus for apb_arbiter with a transaction-level reference model
// that predicts every output on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_apb_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            PCLK;
    logic            PRESETn;
    logic [1:0]      req_valid;
    logic [1:0]      req_write;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      req_ready;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic [AW-1:0]   PADDR;
    logic            PWRITE;
    logic [DW-1:0]   PWDATA;
    logic            PSEL;
    logic            PENABLE;
    logic [DW-1:0]   PRDATA;
    logic            PREADY;

    apb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // ---------------- completer model ----------------
    logic        tie_ready;    // PREADY forced high
    int          slave_waits;  // wait states before PREADY; negative = never
    logic [31:0] slave_rdata;
    int          acc_cnt;

    assign PRDATA = slave_rdata;
    assign PREADY = tie_ready |
                    (PSEL & PENABLE & (slave_waits >= 0) & (acc_cnt == slave_waits));

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
    end

    // ---------------- bookkeeping ----------------
    int checks;
    int errors;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // One transfer in flight: m_age 0 = address phase, >=1 = data phase.
    bit          m_busy;
    int          m_age;
    int          m_waits;
    int          m_owner;
    int          m_last;
    logic        m_pwrite;
    logic [7:0]  m_paddr;
    logic [31:0] m_pwdata;
    bit          m_rsp;
    int          m_rsp_owner;
    logic [31:0] m_rsp_rdata;
    bit          m_rsp_err;

    function automatic int pick(input logic [1:0] v, input int last);
        if (v == 2'b11) return (last == 1) ? 0 : 1;
        return v[1] ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_waits = 0; m_owner = 0;
        m_last = 1;  // requester 0 wins first contest
        m_pwrite = 1'b0; m_paddr = '0; m_pwdata = '0;
        m_rsp = 0; m_rsp_owner = 0; m_rsp_rdata = '0; m_rsp_err = 0;
    endtask

    // statistics observed on the DUT, for literal expectations
    int cyc;
    int psel_cnt;
    int pen_cnt;
    int rsp_cnt;
    int rsp_cyc;
    logic [1:0]  last_rsp_valid;
    logic [31:0] last_rsp_rdata;
    logic        last_rsp_err;
    int hs_idx[$];
    int hs_cyc[$];

    task automatic clear_stats();
        psel_cnt = 0; pen_cnt = 0; rsp_cnt = 0; rsp_cyc = 0;
        hs_idx.delete(); hs_cyc.delete();
    endtask

    always @(negedge PCLK) begin
        logic [1:0] e_ready;
        logic [1:0] e_rsp;
        int w;
        cyc++;
        if (!PRESETn) model_reset();

        e_ready = 2'b00;
        if (!m_busy && req_valid != 2'b00)
            e_ready = (pick(req_valid, m_last) == 1) ? 2'b10 : 2'b01;
        e_rsp = m_rsp ? ((m_rsp_owner == 1) ? 2'b10 : 2'b01) : 2'b00;

        check("req_ready", 64'(req_ready), 64'(e_ready));
        check("PSEL",      64'(PSEL),      64'(m_busy));
        check("PENABLE",   64'(PENABLE),   64'(m_busy && (m_age >= 1)));
        check("PADDR",     64'(PADDR),     64'(m_paddr));
        check("PWRITE",    64'(PWRITE),    64'(m_pwrite));
        check("PWDATA",    64'(PWDATA),    64'(m_pwdata));
        check("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
        if (m_rsp) begin
            check("rsp_rdata", 64'(rsp_rdata), 64'(m_rsp_rdata));
            check("rsp_err",   64'(rsp_err),   64'(m_rsp_err));
        end

        if (PSEL)    psel_cnt++;
        if (PENABLE) pen_cnt++;
        if (rsp_valid != 2'b00) begin
            rsp_cnt++;
            rsp_cyc        = cyc;
            last_rsp_valid = rsp_valid;
            last_rsp_rdata = rsp_rdata;
            last_rsp_err   = rsp_err;
        end
        for (int i = 0; i < 2; i++) begin
            if (req_ready[i] && req_valid[i]) begin
                hs_idx.push_back(i);
                hs_cyc.push_back(cyc);
            end
        end

        // advance the model to the state after the coming rising edge
        if (PRESETn) begin
            m_rsp = 0;
            if (!m_busy) begin
                if (req_valid != 2'b00) begin
                    w        = pick(req_valid, m_last);
                    m_owner  = w;
                    m_last   = w;
                    m_pwrite = req_write[w];
                    m_paddr  = req_addr[w*AW +: AW];
                    m_pwdata = req_wdata[w*DW +: DW];
                    m_busy   = 1; m_age = 0; m_waits = 0;
                end
            end else if (m_age == 0) begin
                m_age = 1;
            end else if (PREADY) begin
                m_rsp = 1; m_rsp_owner = m_owner; m_rsp_err = 0;
                m_rsp_rdata = m_pwrite ? 32'h0 : PRDATA;
                m_busy = 0;
            end else begin
                m_waits++;
                if (m_waits == TO) begin
                    m_rsp = 1; m_rsp_owner = m_owner; m_rsp_err = 1;
                    m_rsp_rdata = 32'h0;
                    m_busy = 0;
                end else begin
                    m_age++;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input int idx, input logic wr, input logic [7:0] a, input logic [31:0] d);
        int n;
        req_write[idx]          = wr;
        req_addr[idx*AW +: AW]  = a;
        req_wdata[idx*DW +: DW] = d;
        req_valid[idx]          = 1'b1;
        n = 0;
        while (n < 50 && !req_ready[idx]) begin
            @(negedge PCLK); #1;
            n++;
        end
        check("grant_seen", 64'(req_ready[idx]), 64'd1);
        @(posedge PCLK); #1;
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_rsp(input int n_before, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(posedge PCLK);
            if (rsp_cnt > n_before) break;
        end
        #1;
        check("rsp_seen", 64'(rsp_cnt), 64'(n_before + 1));
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        PRESETn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        tie_ready = 1'b0; slave_waits = 0; slave_rdata = '0; acc_cnt = 0;
        last_rsp_valid = '0; last_rsp_rdata = '0; last_rsp_err = 1'b0;
        clear_stats();

        // reset state
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_PSEL",      64'(PSEL),      64'd0);
        check("rst_PENABLE",   64'(PENABLE),   64'd0);
        check("rst_PWRITE",    64'(PWRITE),    64'd0);
        check("rst_PADDR",     64'(PADDR),     64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // requester 0 write, PREADY tied high
        tie_ready = 1'b1; slave_waits = 0;
        clear_stats();
        issue(0, 1'b1, 8'h01, 32'h1122_3344);
        wait_rsp(0, 20);
        check("t1_latency",   64'(rsp_cyc - hs_cyc[0]), 64'd3);
        check("t1_psel_cyc",  64'(psel_cnt),            64'd2);
        check("t1_pen_cyc",   64'(pen_cnt),             64'd1);
        check("t1_rsp_valid", 64'(last_rsp_valid),      64'h1);
        check("t1_rsp_rdata", 64'(last_rsp_rdata),      64'h0);

        // requester 1 read with 2 wait states
        tie_ready = 1'b0; slave_waits = 2; slave_rdata = 32'h1122_3344;
        clear_stats();
        issue(1, 1'b0, 8'h01, 32'h0);
        wait_rsp(0, 20);
        check("t2_rsp_valid", 64'(last_rsp_valid),      64'h2);
        check("t2_rsp_rdata", 64'(last_rsp_rdata),      64'h1122_3344);
        check("t2_rsp_err",   64'(last_rsp_err),        64'd0);
        check("t2_latency",   64'(rsp_cyc - hs_cyc[0]), 64'd5);

        // both requesters continuously valid
        slave_waits = 0;
        clear_stats();
        req_write = 2'b11;
        req_addr  = {8'h03, 8'h02};
        req_wdata = {32'hB1B1_0003, 32'hA0A0_0002};
        req_valid = 2'b11;
        for (int i = 0; i < 60; i++) begin
            @(negedge PCLK); #1;
            if (hs_idx.size() >= 4) break;
        end
        @(posedge PCLK); #1;
        req_valid = 2'b00;
        check("t3_grants", 64'(hs_idx.size()), 64'd4);
        check("t3_order0", 64'(hs_idx[0]), 64'd0);
        check("t3_order1", 64'(hs_idx[1]), 64'd1);
        check("t3_order2", 64'(hs_idx[2]), 64'd0);
        check("t3_order3", 64'(hs_idx[3]), 64'd1);
        check("t3_b2b_gap", 64'(hs_cyc[1] - hs_cyc[0]), 64'd3);
        wait_rsp(3, 20);

        // timeout: PREADY never arrives
        slave_waits = -1; slave_rdata = 32'hDEAD_BEEF;
        clear_stats();
        issue(0, 1'b0, 8'h05, 32'h0);
        wait_rsp(0, 40);
        check("t4_rsp_valid", 64'(last_rsp_valid),      64'h1);
        check("t4_rsp_err",   64'(last_rsp_err),        64'd1);
        check("t4_rsp_rdata", 64'(last_rsp_rdata),      64'h0);
        check("t4_psel_cyc",  64'(psel_cnt),            64'd17);
        check("t4_pen_cyc",   64'(pen_cnt),             64'd16);
        check("t4_latency",   64'(rsp_cyc - hs_cyc[0]), 64'd18);
        @(posedge PCLK); #1;
        check("t4_idle", 64'(PSEL), 64'd0);

        // reset in the middle of ACCESS
        clear_stats();
        issue(0, 1'b1, 8'h07, 32'hCAFE_F00D);
        for (int i = 0; i < 10; i++) begin
            @(negedge PCLK); #1;
            if (PENABLE) break;
        end
        check("t5_in_access", 64'(PENABLE), 64'd1);
        repeat (2) @(posedge PCLK);
        #2;
        PRESETn = 1'b0;
        #1;
        check("t5_rst_PSEL",    64'(PSEL),    64'd0);
        check("t5_rst_PENABLE", 64'(PENABLE), 64'd0);
        check("t5_rst_PADDR",   64'(PADDR),   64'd0);
        repeat (2) @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
        slave_waits = 0;
        check("t5_no_rsp", 64'(rsp_cnt), 64'd0);

        clear_stats();
        req_write = 2'b00;
        req_addr  = {8'h11, 8'h10};
        req_valid = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(negedge PCLK); #1;
            if (hs_idx.size() >= 1) break;
        end
        @(posedge PCLK); #1;
        req_valid = 2'b00;
        check("t5_grants",    64'(hs_idx.size()), 64'd1);
        check("t5_first_win", 64'(hs_idx[0]),     64'd0);
        wait_rsp(0, 20);

        repeat (2) @(posedge PCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_apb_arbiter
